// File: rtl/ws281x_driver_if.sv
// Pixel hand-off between one ws281x register-block port FIFO (master) and its line driver (slave).
interface ws281x_driver_if;
   logic        port_enb;
   logic        port_dval;
   logic [23:0] port_data;
   logic        port_rd;

   modport master (output port_enb, output port_dval, output port_data, input port_rd);
   modport slave  (input port_enb, input port_dval, input port_data, output port_rd);
endinterface

// File: rtl/ws281x_driver.sv
// WS281x NRZ line driver: pops 24-bit GRB pixels from a show-ahead FIFO and
// serialises them MSB-first, followed by a configurable low reset gap.
module ws281x_driver (
   input  logic                   mclk,
   input  logic                   h_reset,
   input  logic [15:0]            cfg_reset_period,
   input  logic [9:0]             cfg_clk_period,
   input  logic [9:0]             cfg_th0_period,
   input  logic [9:0]             cfg_th1_period,
   ws281x_driver_if.slave         fifo_port,
   output logic                   txd,
   output logic                   busy
);

   typedef enum logic [1:0] {S_IDLE, S_TX, S_RST} state_t;

   state_t      state_reg, state_next;
   logic [23:0] shift_reg, shift_next;
   logic [4:0]  bit_cnt_reg, bit_cnt_next;
   logic [9:0]  cyc_reg, cyc_next;
   logic [9:0]  per_reg, per_next;
   logic [9:0]  th0_reg, th0_next;
   logic [9:0]  th1_reg, th1_next;
   logic [15:0] rlen_reg, rlen_next;
   logic [15:0] rst_cnt_reg, rst_cnt_next;
   logic        txd_reg, txd_next;

   logic        pixel_avail;
   logic        bit_last;
   logic        pixel_last;
   logic        load;
   logic [9:0]  th_cur;

   // Reset gates the pop so an asserted reset can never consume a FIFO entry.
   assign pixel_avail = fifo_port.port_enb & fifo_port.port_dval & ~h_reset;
   assign bit_last    = (cyc_reg == per_reg - 10'd1);
   assign pixel_last  = bit_last & (bit_cnt_reg == 5'd23);
   assign th_cur      = shift_reg[23] ? th1_reg : th0_reg;

   always_ff @(posedge mclk or posedge h_reset) begin
      if (h_reset) begin
         state_reg   <= S_IDLE;
         shift_reg   <= 24'd0;
         bit_cnt_reg <= 5'd0;
         cyc_reg     <= 10'd0;
         per_reg     <= 10'd0;
         th0_reg     <= 10'd0;
         th1_reg     <= 10'd0;
         rlen_reg    <= 16'd0;
         rst_cnt_reg <= 16'd0;
         txd_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         cyc_reg     <= cyc_next;
         per_reg     <= per_next;
         th0_reg     <= th0_next;
         th1_reg     <= th1_next;
         rlen_reg    <= rlen_next;
         rst_cnt_reg <= rst_cnt_next;
         txd_reg     <= txd_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      cyc_next     = cyc_reg;
      per_next     = per_reg;
      th0_next     = th0_reg;
      th1_next     = th1_reg;
      rlen_next    = rlen_reg;
      rst_cnt_next = rst_cnt_reg;
      txd_next     = 1'b0;
      load         = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (pixel_avail) load = 1'b1;
         end
         S_TX: begin
            if (pixel_last) begin
               if (pixel_avail) begin
                  load = 1'b1;
               end else begin
                  state_next   = S_RST;
                  rlen_next    = (cfg_reset_period == 16'd0) ? 16'd1 : cfg_reset_period;
                  rst_cnt_next = 16'd0;
               end
            end else if (bit_last) begin
               cyc_next     = 10'd0;
               shift_next   = {shift_reg[22:0], 1'b0};
               bit_cnt_next = bit_cnt_reg + 5'd1;
               // Next bit starts at cyc 0, so it is high iff its threshold is non-zero.
               txd_next     = shift_reg[22] ? (th1_reg != 10'd0) : (th0_reg != 10'd0);
            end else begin
               cyc_next = cyc_reg + 10'd1;
               txd_next = ((cyc_reg + 10'd1) < th_cur);
            end
         end
         S_RST: begin
            if (rst_cnt_reg == rlen_reg - 16'd1) state_next = S_IDLE;
            else                                 rst_cnt_next = rst_cnt_reg + 16'd1;
         end
         default: state_next = S_IDLE;
      endcase

      if (load) begin
         state_next   = S_TX;
         shift_next   = fifo_port.port_data;
         per_next     = (cfg_clk_period == 10'd0) ? 10'd1 : cfg_clk_period;
         th0_next     = cfg_th0_period;
         th1_next     = cfg_th1_period;
         bit_cnt_next = 5'd0;
         cyc_next     = 10'd0;
         txd_next     = fifo_port.port_data[23] ? (cfg_th1_period != 10'd0)
                                                : (cfg_th0_period != 10'd0);
      end
   end

   assign fifo_port.port_rd = load;
   assign txd               = txd_reg;
   assign busy              = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ws281x_driver.sv
// Directed bench for ws281x_driver: a queue models the show-ahead FIFO, traces are checked per transaction.
module tb_ws281x_driver;
   logic        mclk = 1'b0;
   logic        h_reset = 1'b1;
   logic [15:0] cfg_reset_period;
   logic [9:0]  cfg_clk_period;
   logic [9:0]  cfg_th0_period;
   logic [9:0]  cfg_th1_period;
   logic        txd;
   logic        busy;

   ws281x_driver_if fifo_port();

   ws281x_driver dut (
      .mclk             (mclk),
      .h_reset          (h_reset),
      .cfg_reset_period (cfg_reset_period),
      .cfg_clk_period   (cfg_clk_period),
      .cfg_th0_period   (cfg_th0_period),
      .cfg_th1_period   (cfg_th1_period),
      .fifo_port        (fifo_port),
      .txd              (txd),
      .busy             (busy)
   );

   always #5 mclk = ~mclk;

   int          checks = 0;
   int          failures = 0;
   logic [23:0] fifo[$];
   logic        rd_tr   [0:799];
   logic        txd_tr  [0:799];
   logic        busy_tr [0:799];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic refresh();
      fifo_port.port_dval = (fifo.size() != 0);
      fifo_port.port_data = (fifo.size() != 0) ? fifo[0] : 24'h0;
   endtask

   // Runs n cycles from just after a rising edge; ev_kind 1 drops enable, 2 changes the bit period.
   task automatic watch(input int n, input int ev_cyc, input int ev_kind);
      for (int i = 0; i < n; i++) begin
         if (i == ev_cyc) begin
            if (ev_kind == 1)      fifo_port.port_enb = 1'b0;
            else if (ev_kind == 2) cfg_clk_period = 10'd20;
         end
         @(negedge mclk);
         rd_tr[i]   = fifo_port.port_rd;
         txd_tr[i]  = txd;
         busy_tr[i] = busy;
         @(posedge mclk);
         #1;
         if (rd_tr[i] === 1'b1 && fifo.size() != 0) void'(fifo.pop_front());
         refresh();
      end
   endtask

   function automatic logic model_txd(input logic [23:0] pix, input int per, input int th0,
                                      input int th1, input int k);
      int p;
      int b;
      int c;
      p = (per == 0) ? 1 : per;
      b = k / p;
      c = k % p;
      return (c < (pix[23-b] ? th1 : th0));
   endfunction

   function automatic int count_diff(input int sel, input int start, input int len, input logic v);
      int   n;
      logic o;
      n = 0;
      for (int k = start; k < start + len; k++) begin
         o = (sel == 0) ? txd_tr[k] : (sel == 1) ? busy_tr[k] : rd_tr[k];
         if (o !== v) n++;
      end
      return n;
   endfunction

   function automatic int count_rd(input int start, input int len);
      int n;
      n = 0;
      for (int k = start; k < start + len; k++) if (rd_tr[k] === 1'b1) n++;
      return n;
   endfunction

   task automatic chk_txd(input string tag, input int start, input logic [23:0] pa, input int per_a,
                          input logic [23:0] pb, input int per_b, input int npix,
                          input int th0, input int th1);
      int   bad;
      int   first;
      int   la;
      int   lb;
      logic e;
      bad   = 0;
      first = -1;
      la    = 24 * ((per_a == 0) ? 1 : per_a);
      lb    = (npix == 2) ? 24 * ((per_b == 0) ? 1 : per_b) : 0;
      for (int k = 0; k < la + lb; k++) begin
         e = (k < la) ? model_txd(pa, per_a, th0, th1, k) : model_txd(pb, per_b, th0, th1, k - la);
         if (txd_tr[start + k] !== e) begin
            bad++;
            if (first < 0) first = start + k;
         end
      end
      chk($sformatf("%s bad_cycles first_bad=%0d", tag, first), bad, 0);
   endtask

   initial begin
      cfg_reset_period    = 16'd20;
      cfg_clk_period      = 10'd10;
      cfg_th0_period      = 10'd3;
      cfg_th1_period      = 10'd7;
      fifo_port.port_enb  = 1'b1;
      refresh();

      repeat (3) @(posedge mclk);
      @(negedge mclk);
      chk("reset_txd", txd, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rd", fifo_port.port_rd, 0);
      @(posedge mclk); #1;
      h_reset = 1'b0;
      @(posedge mclk); #1;

      // single pixel 0xA50000
      fifo.push_back(24'hA50000); refresh();
      watch(280, -1, 0);
      $display("txn single_pixel pops=%0d", count_rd(0, 280));
      chk("t1_rd_cycle0", rd_tr[0], 1);
      chk("t1_pop_count", count_rd(0, 280), 1);
      chk("t1_txd_c0", txd_tr[0], 0);
      chk("t1_bit23_high_end", txd_tr[7], 1);
      chk("t1_bit23_low_start", txd_tr[8], 0);
      chk("t1_bit22_high_end", txd_tr[13], 1);
      chk("t1_bit22_low_start", txd_tr[14], 0);
      chk_txd("t1_wave", 1, 24'hA50000, 10, 24'h0, 10, 1, 3, 7);
      chk("t1_gap_low", count_diff(0, 241, 39, 1'b0), 0);
      chk("t1_busy_c0", busy_tr[0], 0);
      chk("t1_busy_span", count_diff(1, 1, 260, 1'b1), 0);
      chk("t1_busy_fall", busy_tr[261], 0);

      // back-to-back pixels
      fifo.push_back(24'h00FF81); fifo.push_back(24'h8000FF); refresh();
      watch(520, -1, 0);
      $display("txn back_to_back pops=%0d", count_rd(0, 520));
      chk("t2_pop_count", count_rd(0, 520), 2);
      chk("t2_second_pop", rd_tr[240], 1);
      chk_txd("t2_wave", 1, 24'h00FF81, 10, 24'h8000FF, 10, 2, 3, 7);
      chk("t2_gap_low", count_diff(0, 481, 39, 1'b0), 0);
      chk("t2_busy_last", busy_tr[500], 1);
      chk("t2_busy_fall", busy_tr[501], 0);
      chk("t2_fifo_empty", fifo.size(), 0);

      // enable dropped at bit 5 of pixel 1
      fifo.push_back(24'h3C0001); fifo.push_back(24'h555555); refresh();
      watch(300, 51, 1);
      $display("txn enable_drop pops=%0d", count_rd(0, 300));
      chk("t3_pop_count", count_rd(0, 300), 1);
      chk_txd("t3_wave", 1, 24'h3C0001, 10, 24'h0, 10, 1, 3, 7);
      chk("t3_gap_low", count_diff(0, 241, 59, 1'b0), 0);
      chk("t3_busy_fall", busy_tr[261], 0);
      chk("t3_fifo_left", fifo.size(), 1);
      fifo_port.port_enb = 1'b1;
      watch(262, -1, 0);
      $display("txn enable_restore pops=%0d", count_rd(0, 262));
      chk("t3_resume_pop", rd_tr[0], 1);
      chk_txd("t3_resume_wave", 1, 24'h555555, 10, 24'h0, 10, 1, 3, 7);
      chk("t3_resume_busy_fall", busy_tr[261], 0);

      // per=0 behaves as 1, reset_period=0 gives one RST cycle
      cfg_clk_period = 10'd0; cfg_th0_period = 10'd0; cfg_th1_period = 10'd1; cfg_reset_period = 16'd0;
      fifo.push_back(24'hA5C33C); refresh();
      watch(30, -1, 0);
      $display("txn per_zero pops=%0d", count_rd(0, 30));
      chk("t4_pop", rd_tr[0], 1);
      chk("t4_pop_count", count_rd(0, 30), 1);
      chk_txd("t4_wave", 1, 24'hA5C33C, 0, 24'h0, 0, 1, 0, 1);
      chk("t4_rst_txd", txd_tr[25], 0);
      chk("t4_rst_busy", busy_tr[25], 1);
      chk("t4_idle_busy", busy_tr[26], 0);

      // full-high (th1 >= per) and full-low (th0 = 0) bits
      cfg_clk_period = 10'd10; cfg_th0_period = 10'd0; cfg_th1_period = 10'd15;
      fifo.push_back(24'hF0F00F); refresh();
      watch(245, -1, 0);
      $display("txn full_high_low pops=%0d", count_rd(0, 245));
      chk_txd("t5_wave", 1, 24'hF0F00F, 10, 24'h0, 10, 1, 0, 15);
      chk("t5_first_bit_high", count_diff(0, 1, 10, 1'b1), 0);
      chk("t5_rst_busy", busy_tr[241], 1);
      chk("t5_idle_busy", busy_tr[242], 0);

      // async reset during bit 12
      cfg_th0_period = 10'd3; cfg_th1_period = 10'd7; cfg_reset_period = 16'd20;
      fifo.push_back(24'hFFFFFF); fifo.push_back(24'h0F0F0F); refresh();
      watch(125, -1, 0);
      #1;
      chk("t6_pre_reset_txd", txd, 1);
      h_reset = 1'b1;
      #1;
      chk("t6_reset_txd", txd, 0);
      chk("t6_reset_busy", busy, 0);
      @(negedge mclk);
      chk("t6_reset_no_rd", fifo_port.port_rd, 0);
      @(posedge mclk); #1;
      chk("t6_fifo_kept", fifo.size(), 1);
      h_reset = 1'b0;
      watch(262, -1, 0);
      $display("txn async_reset pops=%0d", count_rd(0, 262));
      chk("t6_restart_pop", rd_tr[0], 1);
      chk_txd("t6_restart_wave", 1, 24'h0F0F0F, 10, 24'h0, 10, 1, 3, 7);
      chk("t6_busy_fall", busy_tr[261], 0);

      // bit period changed mid-pixel
      fifo.push_back(24'h800001); fifo.push_back(24'hC00003); refresh();
      watch(745, 50, 2);
      $display("txn cfg_change pops=%0d", count_rd(0, 745));
      chk("t7_pop_count", count_rd(0, 745), 2);
      chk("t7_second_pop", rd_tr[240], 1);
      chk_txd("t7_wave", 1, 24'h800001, 10, 24'hC00003, 20, 2, 3, 7);
      chk("t7_busy_last", busy_tr[740], 1);
      chk("t7_busy_fall", busy_tr[741], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ws281x_driver.md
Name: ws281x_driver

Overview:
- Serial line driver for one WS281x LED chain.
- Sits directly downstream of one port of the ws281x register block: pops 24-bit GRB pixels from that port's show-ahead data FIFO and serialises them MSB-first onto a single NRZ pulse-width line.
- Bit timing and the end-of-frame reset gap come from the shared config registers.
- One instance per port.

Parameters:
- None. Widths are fixed by the register block: data 24, clk/th periods 10, reset period 16.

Ports:
mclk  input  1  system clock
h_reset  input  1  asynchronous active-high reset
cfg_reset_period  input  16  low time after frame end, in mclk cycles
cfg_clk_period  input  10  total bit period, in mclk cycles
cfg_th0_period  input  10  high time for a 0 bit
cfg_th1_period  input  10  high time for a 1 bit
port_enb  input  1  port enable
port_dval  input  1  FIFO non-empty; port_data is valid
port_data  input  24  head-of-FIFO pixel (show-ahead)
port_rd  output  1  FIFO pop strobe, one mclk wide
txd  output  1  serial output to the LED chain
busy  output  1  high in TX and RST states

Behaviour:
- Clock and reset: single clock mclk. h_reset is asynchronous, active-high.
- Reset values: state=IDLE, txd=0, busy=0, port_rd=0. Shift register, bit counter and cycle counter are 0.
- Reset mid-operation: txd drops to 0 immediately (async). No pop occurs. The interrupted pixel is lost.
- FSM states: IDLE, TX, RST.
- port_rd (Mealy, combinational):
  - Equals (IDLE & port_enb & port_dval) | (TX & last cycle of bit 23 & port_enb & port_dval).
  - Never asserted when port_dval=0.
- Pixel load:
  - On the edge where port_rd=1, capture port_data into the shift register.
  - On the same edge, latch per = max(cfg_clk_period,1), th0 = cfg_th0_period, th1 = cfg_th1_period.
  - Set bit_cnt=0 and cyc=0, enter or remain in TX.
  - Config changes take effect only at the next pixel load.
- TX timing:
  - cyc counts 0..per-1. txd = (cyc < thX), where X is the current MSB of the shift register.
  - txd is registered, so it is aligned with cyc. The first high cycle is the cycle after port_rd.
  - If thX >= per, txd stays high for the whole bit. If thX = 0, txd stays low for the whole bit.
  - At cyc=per-1: cyc wraps to 0, the shift register shifts left, bit_cnt increments.
- End of pixel (cyc=per-1 and bit_cnt=23):
  - If port_enb & port_dval: pop and load the next pixel with no gap between pixels.
  - Otherwise go to RST and latch rlen = max(cfg_reset_period,1).
- port_enb deasserted mid-pixel: the current pixel completes all 24 bits, then the FSM goes to RST. Pixels are never truncated.
- RST state: txd=0 for exactly rlen cycles, then IDLE. No pop occurs during RST, even if port_dval=1. Re-evaluation happens in IDLE.
- IDLE state: txd=0, busy=0.
- Pixel length: 24*per cycles. Frame-end low time: at least rlen cycles, plus the low tail of the last bit.

Test Plan:
- Single pixel: per=10, th0=3, th1=7, reset=20, one pixel 0xA50000, enb=1.
  - port_rd pulses once at cycle 0.
  - From cycle 1, bit pattern 1,0,1,0,0,1,0,1 then 16 zeros.
  - Each 1 bit is 7 high + 3 low; each 0 bit is 3 high + 7 low.
  - txd then low for 20 cycles, busy falls at cycle 241+20.
- Back-to-back: two pixels queued.
  - Second port_rd at cycle 240.
  - First bit of pixel 2 starts at cycle 241 with no extra low cycles.
  - Exactly two pops total.
- Enable drop: port_enb cleared at bit 5 of pixel 1 while a second pixel is queued.
  - Pixel 1 completes all 24 bits, then RST.
  - No second pop; port_dval stays 1.
- Boundaries:
  - per=0 is treated as 1.
  - th1=15 with per=10 gives a full-high bit.
  - th0=0 gives a full-low bit.
  - reset_period=0 gives a 1-cycle RST.
- Async reset: assert h_reset at bit 12.
  - txd=0 and busy=0 immediately.
  - After release with port_dval=1, a new pop occurs and the next pixel starts cleanly from bit 23.
- Config change mid-pixel: change cfg_clk_period from 10 to 20 during pixel 1.
  - Pixel 1 keeps 10-cycle bits.
  - Pixel 2 uses 20-cycle bits.
